// File: rtl/multi_cycle_ctrl_pkg.sv
// Shared opcode, state and control-code definitions for the multi-cycle CPU controller.
// instrOf() turns a raw 6-bit opcode into a symbolic instruction for the FSM and decoder.
package cpu_defs;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_ADDIU = 6'b000010;
  localparam logic [5:0] OP_ANDI  = 6'b010000;
  localparam logic [5:0] OP_ORI   = 6'b010010;
  localparam logic [5:0] OP_SLT   = 6'b100110;
  localparam logic [5:0] OP_SW    = 6'b110000;
  localparam logic [5:0] OP_LW    = 6'b110001;
  localparam logic [5:0] OP_BEQ   = 6'b110100;
  localparam logic [5:0] OP_BNE   = 6'b110101;
  localparam logic [5:0] OP_J     = 6'b111000;
  localparam logic [5:0] OP_JR    = 6'b111001;
  localparam logic [5:0] OP_JAL   = 6'b111010;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  typedef enum logic [2:0] {
    ST_IF     = 3'b000,
    ST_ID     = 3'b001,
    ST_EXE_LS = 3'b010,
    ST_MEM    = 3'b011,
    ST_WB_L   = 3'b100,
    ST_EXE_BR = 3'b101,
    ST_EXE_AL = 3'b110,
    ST_WB_AL  = 3'b111
  } state_e;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b100;
  localparam logic [2:0] ALU_AND = 3'b101;

  localparam logic [1:0] PC_NEXT   = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_RS     = 2'b10;
  localparam logic [1:0] PC_JUMP   = 2'b11;

  localparam logic [1:0] RD_RA = 2'b00;
  localparam logic [1:0] RD_RT = 2'b01;
  localparam logic [1:0] RD_RD = 2'b10;

  typedef enum logic [3:0] {
    I_ADD, I_SUB, I_ADDIU, I_ANDI, I_ORI, I_SLT,
    I_SW, I_LW, I_BEQ, I_BNE,
    I_J, I_JR, I_JAL, I_HALT, I_BAD
  } instr_e;

  function automatic instr_e instrOf(input logic [5:0] op);
    instr_e i;
    case (op)
      OP_ADD:   i = I_ADD;
      OP_SUB:   i = I_SUB;
      OP_ADDIU: i = I_ADDIU;
      OP_ANDI:  i = I_ANDI;
      OP_ORI:   i = I_ORI;
      OP_SLT:   i = I_SLT;
      OP_SW:    i = I_SW;
      OP_LW:    i = I_LW;
      OP_BEQ:   i = I_BEQ;
      OP_BNE:   i = I_BNE;
      OP_J:     i = I_J;
      OP_JR:    i = I_JR;
      OP_JAL:   i = I_JAL;
      OP_HALT:  i = I_HALT;
      default:  i = I_BAD;
    endcase
    return i;
  endfunction

endpackage

// File: rtl/multi_cycle_ctrl_decode.sv
// Combinational control decode from the current state and decoded instruction.
// Write enables are forced low while Reset is asserted, independent of the clock.
module ctrl_decode
  import cpu_defs::*;
(
  input  logic       Reset,
  input  state_e     State,
  input  instr_e     Instr,
  input  logic       Zero,
  output logic       PCWre,
  output logic       IRWre,
  output logic       RegWre,
  output logic       mWR,
  output logic       mRD,
  output logic       ALUSrcB,
  output logic       ExtSel,
  output logic       DBDataSrc,
  output logic       WrRegDSrc,
  output logic [1:0] RegDst,
  output logic [1:0] PCSrc,
  output logic [2:0] ALUOp
);

  logic pcWreRaw;
  logic irWreRaw;
  logic regWreRaw;
  logic mWrRaw;

  always_comb begin
    pcWreRaw  = 1'b0;
    irWreRaw  = 1'b0;
    regWreRaw = 1'b0;
    mWrRaw    = 1'b0;
    mRD       = 1'b0;
    case (State)
      ST_IF: irWreRaw = 1'b1;
      ST_ID: begin
        // Jumps and unknown opcodes finish in ID; halt never advances the PC.
        pcWreRaw  = Instr inside {I_J, I_JR, I_JAL, I_BAD};
        regWreRaw = (Instr == I_JAL);
      end
      ST_MEM: begin
        pcWreRaw = (Instr != I_LW);
        mWrRaw   = (Instr == I_SW);
        mRD      = (Instr == I_LW);
      end
      ST_WB_L: begin
        pcWreRaw  = 1'b1;
        regWreRaw = 1'b1;
        mRD       = (Instr == I_LW);
      end
      ST_EXE_BR: pcWreRaw = 1'b1;
      ST_WB_AL: begin
        pcWreRaw  = 1'b1;
        regWreRaw = 1'b1;
      end
      default: ;
    endcase
  end

  assign PCWre  = Reset & pcWreRaw;
  assign IRWre  = Reset & irWreRaw;
  assign RegWre = Reset & regWreRaw;
  assign mWR    = Reset & mWrRaw;

  always_comb begin
    ALUOp = ALU_ADD;
    case (Instr)
      I_SUB, I_BEQ, I_BNE: ALUOp = ALU_SUB;
      I_ORI:               ALUOp = ALU_OR;
      I_ANDI:              ALUOp = ALU_AND;
      I_SLT:               ALUOp = ALU_SLT;
      default:             ALUOp = ALU_ADD;
    endcase
  end

  always_comb begin
    RegDst = RD_RA;
    case (Instr)
      I_ADD, I_SUB, I_SLT:             RegDst = RD_RD;
      I_ADDIU, I_ANDI, I_ORI, I_LW:    RegDst = RD_RT;
      default:                         RegDst = RD_RA;
    endcase
  end

  always_comb begin
    PCSrc = PC_NEXT;
    case (Instr)
      I_J, I_JAL: PCSrc = PC_JUMP;
      I_JR:       PCSrc = PC_RS;
      I_BEQ:      if (State == ST_EXE_BR && Zero)  PCSrc = PC_BRANCH;
      I_BNE:      if (State == ST_EXE_BR && !Zero) PCSrc = PC_BRANCH;
      default:    PCSrc = PC_NEXT;
    endcase
  end

  assign ALUSrcB   = Instr inside {I_ADDIU, I_ANDI, I_ORI, I_LW, I_SW};
  assign ExtSel    = !(Instr inside {I_ANDI, I_ORI});
  assign DBDataSrc = (Instr == I_LW);
  assign WrRegDSrc = (Instr != I_JAL);

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle CPU controller: state register and next-state logic.
// Control outputs come from the combinational ctrl_decode instance.
module multi_cycle_ctrl
  import cpu_defs::*;
#(
  parameter int unsigned OPW = 6
)
(
  input  logic           CLK,
  input  logic           Reset,
  input  logic [OPW-1:0] OpCode,
  input  logic           Zero,
  output logic           PCWre,
  output logic           IRWre,
  output logic           RegWre,
  output logic           mWR,
  output logic           mRD,
  output logic           ALUSrcB,
  output logic           ExtSel,
  output logic           DBDataSrc,
  output logic           WrRegDSrc,
  output logic [1:0]     RegDst,
  output logic [1:0]     PCSrc,
  output logic [2:0]     ALUOp,
  output logic [2:0]     State
);

  logic [5:0] op6;
  logic       opHigh;
  instr_e     instr;
  state_e     state;

  // Opcodes wider than 6 bits are unrecognised whenever any upper bit is set.
  if (OPW >= 6) begin : gOpWide
    assign op6    = OpCode[5:0];
    assign opHigh = |(OpCode >> 6);
  end else begin : gOpNarrow
    assign op6    = 6'(OpCode);
    assign opHigh = 1'b0;
  end

  assign instr = opHigh ? I_BAD : instrOf(op6);

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state <= ST_IF;
    end else begin
      case (state)
        ST_IF: state <= ST_ID;
        ST_ID: begin
          case (instr)
            I_ADD, I_SUB, I_ADDIU, I_ANDI, I_ORI, I_SLT: state <= ST_EXE_AL;
            I_SW, I_LW:                                  state <= ST_EXE_LS;
            I_BEQ, I_BNE:                                state <= ST_EXE_BR;
            I_HALT:                                      state <= ST_ID;
            default:                                     state <= ST_IF;
          endcase
        end
        ST_EXE_AL: state <= ST_WB_AL;
        ST_EXE_LS: state <= ST_MEM;
        ST_MEM:    state <= (instr == I_LW) ? ST_WB_L : ST_IF;
        default:   state <= ST_IF;
      endcase
    end
  end

  assign State = state;

  ctrl_decode uDecode (
    .Reset     (Reset),
    .State     (state),
    .Instr     (instr),
    .Zero      (Zero),
    .PCWre     (PCWre),
    .IRWre     (IRWre),
    .RegWre    (RegWre),
    .mWR       (mWR),
    .mRD       (mRD),
    .ALUSrcB   (ALUSrcB),
    .ExtSel    (ExtSel),
    .DBDataSrc (DBDataSrc),
    .WrRegDSrc (WrRegDSrc),
    .RegDst    (RegDst),
    .PCSrc     (PCSrc),
    .ALUOp     (ALUOp)
  );

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Self-checking bench for multi_cycle_ctrl: directed table, random instruction stream
// against a per-cycle instruction model, and hand-written halt/reset sequences.
module tb_multi_cycle_ctrl;

  localparam logic [5:0] O_ADD = 6'b000000, O_SUB = 6'b000001, O_ADDIU = 6'b000010;
  localparam logic [5:0] O_ANDI = 6'b010000, O_ORI = 6'b010010, O_SLT = 6'b100110;
  localparam logic [5:0] O_SW = 6'b110000, O_LW = 6'b110001;
  localparam logic [5:0] O_BEQ = 6'b110100, O_BNE = 6'b110101;
  localparam logic [5:0] O_J = 6'b111000, O_JR = 6'b111001, O_JAL = 6'b111010;
  localparam logic [5:0] O_HALT = 6'b111111;

  logic       CLK = 1'b0;
  logic       Reset = 1'b0;
  logic [5:0] OpCode = '0;
  logic       Zero = 1'b0;
  logic       PCWre, IRWre, RegWre, mWR, mRD, ALUSrcB, ExtSel, DBDataSrc, WrRegDSrc;
  logic [1:0] RegDst, PCSrc;
  logic [2:0] ALUOp, State;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  multi_cycle_ctrl #(.OPW(6)) dut (
    .CLK(CLK), .Reset(Reset), .OpCode(OpCode), .Zero(Zero),
    .PCWre(PCWre), .IRWre(IRWre), .RegWre(RegWre), .mWR(mWR), .mRD(mRD),
    .ALUSrcB(ALUSrcB), .ExtSel(ExtSel), .DBDataSrc(DBDataSrc), .WrRegDSrc(WrRegDSrc),
    .RegDst(RegDst), .PCSrc(PCSrc), .ALUOp(ALUOp), .State(State)
  );

  // Instruction classes: 0 alu, 1 lw, 2 sw, 3 branch, 4 jump/unknown, 5 halt
  function automatic int opClass(input logic [5:0] op);
    case (op)
      O_ADD, O_SUB, O_ADDIU, O_ANDI, O_ORI, O_SLT: return 0;
      O_LW:          return 1;
      O_SW:          return 2;
      O_BEQ, O_BNE:  return 3;
      O_HALT:        return 5;
      default:       return 4;
    endcase
  endfunction

  function automatic int latency(input int c);
    case (c)
      0: return 4;
      1: return 5;
      2: return 4;
      3: return 3;
      default: return 2;
    endcase
  endfunction

  function automatic logic [2:0] stateAt(input int c, input int k);
    logic [14:0] p;
    case (c)
      0: p = {3'd0, 3'd1, 3'd6, 3'd7, 3'd0};
      1: p = {3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
      2: p = {3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
      3: p = {3'd0, 3'd1, 3'd5, 3'd0, 3'd0};
      default: p = {3'd0, 3'd1, 3'd0, 3'd0, 3'd0};
    endcase
    if (k < 0 || k > 4) return 3'd0;
    return p[14-3*k -: 3];
  endfunction

  // {State, PCWre, IRWre, RegWre, mWR, mRD, ALUSrcB, ExtSel, DBDataSrc, WrRegDSrc, RegDst, PCSrc, ALUOp}
  function automatic logic [18:0] expVec(input logic [5:0] op, input logic z, input int k);
    int c, len;
    logic last, taken, regW, srcB;
    logic [2:0] alu;
    logic [1:0] rd, pcs;
    c = opClass(op);
    len = latency(c);
    last = (k == len - 1);
    case (op)
      O_SUB, O_BEQ, O_BNE: alu = 3'b001;
      O_ORI:  alu = 3'b100;
      O_ANDI: alu = 3'b101;
      O_SLT:  alu = 3'b010;
      default: alu = 3'b000;
    endcase
    case (op)
      O_ADD, O_SUB, O_SLT: rd = 2'b10;
      O_ADDIU, O_ANDI, O_ORI, O_LW: rd = 2'b01;
      default: rd = 2'b00;
    endcase
    taken = (op == O_BEQ) ? z : !z;
    if (op == O_J || op == O_JAL) pcs = 2'b11;
    else if (op == O_JR) pcs = 2'b10;
    else if (c == 3 && k == 2 && taken) pcs = 2'b01;
    else pcs = 2'b00;
    regW = (last && (c == 0 || c == 1)) || (op == O_JAL && k == 1);
    srcB = (op == O_ADDIU || op == O_ANDI || op == O_ORI || op == O_LW || op == O_SW);
    return {stateAt(c, k), last, (k == 0), regW, (c == 2 && k == 3), (c == 1 && k >= 3),
            srcB, !(op == O_ANDI || op == O_ORI), (op == O_LW), (op != O_JAL), rd, pcs, alu};
  endfunction

  function automatic logic [18:0] actVec();
    return {State, PCWre, IRWre, RegWre, mWR, mRD, ALUSrcB, ExtSel, DBDataSrc, WrRegDSrc,
            RegDst, PCSrc, ALUOp};
  endfunction

  task automatic check(input string name, input logic [18:0] act, input logic [18:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Starts just after a falling edge with State expected at IF; runs until State returns to IF.
  task automatic runInstr(input logic [5:0] op, input int zMode, input string tag,
                          output int cycles, output logic [18:0] lastVec);
    logic [18:0] v;
    bit done;
    cycles = 0;
    done = 0;
    lastVec = '0;
    for (int k = 0; k < 8 && !done; k++) begin
      OpCode = op;
      Zero = (zMode == 2) ? 1'($urandom) : 1'(zMode);
      #1;
      v = actVec();
      check($sformatf("%s_step%0d", tag, k), v, expVec(op, Zero, k));
      lastVec = v;
      @(negedge CLK);
      cycles++;
      if (State == 3'd0) done = 1;
    end
  endtask

  typedef struct {
    logic [5:0] op;
    int         zMode;
    int         expLen;
    logic       expRegWre;
    logic [1:0] expRegDst;
    logic [1:0] expPCSrc;
  } vec_t;

  vec_t tbl[16];

  initial begin
    int cyc;
    logic [18:0] lv;
    logic [5:0] rop;

    tbl[0]  = '{O_ADD,   0, 4, 1'b1, 2'b10, 2'b00};
    tbl[1]  = '{O_SUB,   1, 4, 1'b1, 2'b10, 2'b00};
    tbl[2]  = '{O_ADDIU, 0, 4, 1'b1, 2'b01, 2'b00};
    tbl[3]  = '{O_ANDI,  0, 4, 1'b1, 2'b01, 2'b00};
    tbl[4]  = '{O_ORI,   1, 4, 1'b1, 2'b01, 2'b00};
    tbl[5]  = '{O_SLT,   0, 4, 1'b1, 2'b10, 2'b00};
    tbl[6]  = '{O_LW,    0, 5, 1'b1, 2'b01, 2'b00};
    tbl[7]  = '{O_SW,    1, 4, 1'b0, 2'b00, 2'b00};
    tbl[8]  = '{O_BEQ,   1, 3, 1'b0, 2'b00, 2'b01};
    tbl[9]  = '{O_BEQ,   0, 3, 1'b0, 2'b00, 2'b00};
    tbl[10] = '{O_BNE,   1, 3, 1'b0, 2'b00, 2'b00};
    tbl[11] = '{O_BNE,   0, 3, 1'b0, 2'b00, 2'b01};
    tbl[12] = '{O_J,     0, 2, 1'b0, 2'b00, 2'b11};
    tbl[13] = '{O_JR,    0, 2, 1'b0, 2'b00, 2'b10};
    tbl[14] = '{O_JAL,   1, 2, 1'b1, 2'b00, 2'b11};
    tbl[15] = '{6'b001111, 0, 2, 1'b0, 2'b00, 2'b00};

    // Reset held across clock edges: IF with every enable low, even IRWre
    OpCode = O_JAL;
    repeat (3) @(negedge CLK);
    #1 check("reset_state", {14'd0, State, PCWre, IRWre}, {14'd0, 3'd0, 2'b00});
    check("reset_enables", {15'd0, RegWre, mWR, mRD, 1'b0}, 19'd0);
    @(negedge CLK);
    Reset = 1'b1;

    foreach (tbl[i]) begin
      runInstr(tbl[i].op, tbl[i].zMode, $sformatf("tbl%0d", i), cyc, lv);
      check($sformatf("tbl%0d_latency", i), 19'(cyc), 19'(tbl[i].expLen));
      check($sformatf("tbl%0d_last", i), {14'd0, lv[13], lv[6:5], lv[4:3]},
            {14'd0, tbl[i].expRegWre, tbl[i].expRegDst, tbl[i].expPCSrc});
    end

    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 13))
        0: rop = O_ADD;   1: rop = O_SUB;  2: rop = O_ADDIU; 3: rop = O_ANDI;
        4: rop = O_ORI;   5: rop = O_SLT;  6: rop = O_SW;    7: rop = O_LW;
        8: rop = O_BEQ;   9: rop = O_BNE;  10: rop = O_J;    11: rop = O_JR;
        12: rop = O_JAL;
        default: rop = 6'($urandom);
      endcase
      if (rop == O_HALT) rop = O_ADD;
      runInstr(rop, 2, $sformatf("rnd%0d_op%b", n, rop), cyc, lv);
      check($sformatf("rnd%0d_latency", n), 19'(cyc), 19'(latency(opClass(rop))));
    end

    // Halt parks in ID with all write enables low until a reset pulse
    OpCode = O_HALT;
    #1 check("halt_if", {16'd0, State}, {16'd0, 3'd0});
    @(negedge CLK);
    for (int c = 0; c < 20; c++) begin
      Zero = 1'($urandom);
      #1 check($sformatf("halt_hold%0d", c), {12'd0, State, PCWre, IRWre, RegWre, mWR},
               {12'd0, 3'd1, 4'b0000});
      @(negedge CLK);
    end
    Reset = 1'b0;
    #1 check("halt_reset_async", {12'd0, State, PCWre, IRWre, RegWre, mWR}, {12'd0, 3'd0, 4'b0000});
    @(negedge CLK);
    Reset = 1'b1;

    // Reset dropped while sw is in MEM, away from any rising edge
    OpCode = O_SW;
    Zero = 1'b0;
    repeat (3) @(negedge CLK);
    #1 check("sw_mem_before", {15'd0, State, mWR}, {15'd0, 3'd3, 1'b1});
    #1 Reset = 1'b0;
    #1 check("sw_abort_async", {12'd0, State, PCWre, IRWre, RegWre, mWR}, {12'd0, 3'd0, 4'b0000});
    @(negedge CLK);
    #1 check("sw_abort_held", {12'd0, State, PCWre, RegWre, mWR, mRD}, {12'd0, 3'd0, 4'b0000});
    Reset = 1'b1;
    @(posedge CLK);
    #1 check("post_reset_first_edge", {16'd0, State}, {16'd0, 3'd1});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_cycle_ctrl.md
MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 The block SHALL have parameter OPW, default 6, giving the opcode width.
REQ-002 The block SHALL have port CLK, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port Reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port OpCode, input, OPW bits: opcode from the instruction register.
REQ-005 The block SHALL have port Zero, input, 1 bit: ALU result-equals-zero flag.
REQ-006 The block SHALL have output ports PCWre, IRWre, RegWre, mWR and mRD, 1 bit each: the PC, IR, register-file, data-memory-write and data-memory-read enables.
REQ-007 The block SHALL have output ports ALUSrcB, ExtSel, DBDataSrc and WrRegDSrc, 1 bit each, encoded as:
- ALUSrcB: 1 = extended immediate.
- ExtSel: 1 = sign extension.
- DBDataSrc: 1 = memory data.
- WrRegDSrc: 0 = PC+4.
REQ-008 The block SHALL have output RegDst, 2 bits: 00 = $31, 01 = rt, 10 = rd.
REQ-009 The block SHALL have output PCSrc, 2 bits: 00 = PC+4, 01 = branch target, 10 = rs (jr), 11 = jump target.
REQ-010 The block SHALL have output ALUOp, 3 bits: 000 add, 001 sub, 010 signed slt, 100 or, 101 and.
REQ-011 The block SHALL have output State, 3 bits: current state, for debug.

Function
REQ-012 States SHALL be encoded as:
- IF=000, ID=001, EXE_LS=010, MEM=011, WB_L=100, EXE_BR=101, EXE_AL=110, WB_AL=111.
REQ-013 Recognised opcodes SHALL be:
- Arithmetic/logic: add 000000, sub 000001, addiu 000010, andi 010000, ori 010010, slt 100110.
- Memory: sw 110000, lw 110001.
- Branch: beq 110100, bne 110101.
- Jump: j 111000, jr 111001, jal 111010.
- Stop: halt 111111.
REQ-014 Transitions SHALL be:
- IF->ID always.
- ID->EXE_AL for add/sub/addiu/andi/ori/slt.
- ID->EXE_LS for lw/sw.
- ID->EXE_BR for beq/bne.
- ID->IF for j/jr/jal and for unrecognised opcodes.
- EXE_AL->WB_AL; EXE_LS->MEM; MEM->WB_L for lw, MEM->IF for sw.
- WB_AL, WB_L and EXE_BR->IF.
REQ-015 Halt SHALL hold the FSM in ID with PCWre, IRWre, RegWre and mWR all 0 until Reset.
REQ-016 Control outputs SHALL be combinational in State and OpCode; Zero SHALL affect only PCSrc.
REQ-017 IRWre SHALL be 1 only in IF.
REQ-018 PCWre SHALL be 1 for exactly one cycle per instruction: the last state before returning to IF, or ID for jump and unrecognised opcodes.
REQ-019 RegWre SHALL be 1 only in WB_AL, WB_L, and in ID for jal (RegDst=00, WrRegDSrc=0).
REQ-020 mWR SHALL be 1 only in MEM for sw; mRD SHALL be 1 only in MEM and WB_L for lw.
REQ-021 PCSrc SHALL be:
- 01 in EXE_BR when (beq and Zero) or (bne and not Zero), else 00.
- 11 for j/jal; 10 for jr; 00 otherwise.
REQ-022 ALUOp SHALL be:
- add for addiu/lw/sw.
- sub for sub/beq/bne.
- or for ori; and for andi; slt for slt; add for add.
REQ-023 ALUSrcB SHALL be 1 for addiu/andi/ori/lw/sw.
REQ-024 ExtSel SHALL be 0 for andi/ori, else 1.
REQ-025 RegDst SHALL be 10 for add/sub/slt and 01 for addiu/andi/ori/lw.
REQ-026 DBDataSrc SHALL be 1 only for lw.
REQ-027 Instruction latency in cycles SHALL be: jump 2, branch 3, sw 4, arithmetic/logic 4, lw 5.

Reset
REQ-028 While Reset=0, State SHALL be IF and PCWre, IRWre, RegWre and mWR SHALL be 0, regardless of CLK.
REQ-029 Reset asserted mid-instruction SHALL abort it with no further write enable; after release the first rising CLK edge SHALL move IF->ID.

Structure
REQ-030 Opcode constants, state encodings, ALUOp, PCSrc and RegDst codes SHALL live in shared package cpu_defs.
REQ-031 Next-state logic and the State register SHALL reside in multi_cycle_ctrl; output decode SHALL be sub-module ctrl_decode (purely combinational).

Verification
REQ-032 The bench SHALL check: add (000000) -> states IF,ID,EXE_AL,WB_AL,IF; RegWre=1 only in WB_AL with RegDst=10; PCWre=1 only in WB_AL.
REQ-033 The bench SHALL check: lw (110001) -> 5 cycles; mRD=1 in MEM and WB_L; RegWre=1 in WB_L with DBDataSrc=1; sw (110000) -> 4 cycles, mWR=1 in MEM only.
REQ-034 The bench SHALL check: beq with Zero=1 -> PCSrc=01 in EXE_BR; with Zero=0 -> 00; bne gives the inverse.
REQ-035 The bench SHALL check: jal (111010) -> 2 cycles; in ID RegWre=1, RegDst=00, WrRegDSrc=0, PCSrc=11, PCWre=1.
REQ-036 The bench SHALL check: halt (111111) -> State stays 001 for 20 cycles with all write enables 0; Reset pulse -> State=000.
REQ-037 The bench SHALL check: Reset low in MEM during sw -> mWR drops to 0 immediately; State=000 without a CLK edge.
